// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: sequencer for the ECP5 EHXPLLL dynamic phase-shift port.
// Issues N active-low PHASESTEP pulses on a selected output with fixed
// setup/pulse/gap timing, supervises LOCK, and produces the downstream reset.
module pll_phase_ctrl #(
   parameter int SETUP_CYC = 4,
   parameter int PULSE_CYC = 4,
   parameter int GAP_CYC   = 8,
   parameter int LOCK_WAIT = 1024,
   parameter int CNT_W     = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pll_locked,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_sel,
   input  logic             req_dir,
   input  logic [CNT_W-1:0] req_steps,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] steps_done,
   output logic [1:0]       pll_phasesel,
   output logic             pll_phasedir,
   output logic             pll_phasestep,
   output logic             pll_phaseloadreg,
   output logic             rst_out,
   output logic             lock_lost,
   input  logic             lock_lost_clr
);

   localparam int                LCNT_W   = $clog2(LOCK_WAIT);
   localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_WAIT - 1);
   localparam int                CYC_W    = 16;

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

   state_t             state_q, state_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
   logic [CNT_W-1:0]   steps_q, steps_d;
   logic [CNT_W-1:0]   steps_done_q, steps_done_d;
   logic [1:0]         sel_q, sel_d;
   logic               dir_q, dir_d;
   logic               phasestep_q, phasestep_d;
   logic               done_q, done_d;
   logic               aborted_q, aborted_d;

   logic               lock_meta_q, lock_s_q;
   logic [LCNT_W-1:0]  lock_cnt_q;
   logic               rst_out_q;
   logic               lock_lost_q;
   logic               accept;

   // Lock synchroniser, lock-stable counter, downstream reset and sticky lock-loss flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         lock_cnt_q  <= '0;
         rst_out_q   <= 1'b1;
         lock_lost_q <= 1'b0;
      end else begin
         lock_meta_q <= pll_locked;
         lock_s_q    <= lock_meta_q;
         if (!lock_s_q) begin
            lock_cnt_q <= '0;
            rst_out_q  <= 1'b1;
         end else if (lock_cnt_q == LCNT_MAX) begin
            rst_out_q  <= 1'b0;
         end else begin
            lock_cnt_q <= lock_cnt_q + LCNT_W'(1);
         end
         // a new loss event takes priority over a clear in the same cycle
         if (!lock_s_q && !rst_out_q) begin
            lock_lost_q <= 1'b1;
         end else if (lock_lost_clr) begin
            lock_lost_q <= 1'b0;
         end
      end
   end

   // Sequencer state and registered pin drivers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cyc_q        <= '0;
         step_cnt_q   <= '0;
         steps_q      <= '0;
         steps_done_q <= '0;
         sel_q        <= '0;
         dir_q        <= 1'b0;
         phasestep_q  <= 1'b1;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         step_cnt_q   <= step_cnt_d;
         steps_q      <= steps_d;
         steps_done_q <= steps_done_d;
         sel_q        <= sel_d;
         dir_q        <= dir_d;
         phasestep_q  <= phasestep_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
      end
   end

   assign req_ready = (state_q == IDLE) && !rst_out_q;
   assign accept    = req_valid && req_ready;

   // Next-state: request acceptance, per-state timing, step counting, lock-loss abort
   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      step_cnt_d   = step_cnt_q;
      steps_d      = steps_q;
      steps_done_d = steps_done_q;
      sel_d        = sel_q;
      dir_d        = dir_q;
      done_d       = 1'b0;
      aborted_d    = aborted_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sel_d      = req_sel;
               dir_d      = req_dir;
               steps_d    = req_steps;
               step_cnt_d = '0;
               if (req_steps == '0) begin
                  done_d       = 1'b1;
                  aborted_d    = 1'b0;
                  steps_done_d = '0;
               end else begin
                  state_d = SETUP;
                  cyc_d   = CYC_W'(SETUP_CYC - 1);
               end
            end
         end
         SETUP: begin
            if (cyc_q == '0) begin
               state_d    = PULSE;
               cyc_d      = CYC_W'(PULSE_CYC - 1);
               step_cnt_d = step_cnt_q + CNT_W'(1);
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
         PULSE: begin
            if (cyc_q == '0) begin
               state_d = GAP;
               cyc_d   = CYC_W'(GAP_CYC - 1);
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
         GAP: begin
            if (cyc_q == '0) begin
               if (step_cnt_q < steps_q) begin
                  state_d    = PULSE;
                  cyc_d      = CYC_W'(PULSE_CYC - 1);
                  step_cnt_d = step_cnt_q + CNT_W'(1);
               end else begin
                  state_d      = IDLE;
                  done_d       = 1'b1;
                  aborted_d    = 1'b0;
                  steps_done_d = step_cnt_q;
               end
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
      endcase

      // lock loss overrides whatever the sequencer was about to do;
      // a pulse already started is counted even though it is cut short
      if (state_q != IDLE && !lock_s_q) begin
         state_d      = IDLE;
         step_cnt_d   = step_cnt_q;
         done_d       = 1'b1;
         aborted_d    = 1'b1;
         steps_done_d = step_cnt_q;
      end

      phasestep_d = (state_d != PULSE);
   end

   assign busy             = (state_q != IDLE);
   assign done             = done_q;
   assign aborted          = aborted_q;
   assign steps_done       = steps_done_q;
   assign pll_phasesel     = sel_q;
   assign pll_phasedir     = dir_q;
   assign pll_phasestep    = phasestep_q;
   assign pll_phaseloadreg = 1'b1;
   assign rst_out          = rst_out_q;
   assign lock_lost        = lock_lost_q;

endmodule
